// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter for the register-file write port, with a registered output stage.
// Optional forwarding of the presented write is enabled by defining RF_ARB_FWD_EN.
module rf_wb_arbiter #(
  parameter int unsigned NREQ       = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_waddr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
  input  logic                       stall,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  input  logic [ADDR_WIDTH-1:0]      raddr1,
  input  logic [ADDR_WIDTH-1:0]      raddr2,
  output logic                       fwd1_hit,
  output logic                       fwd2_hit,
  output logic [DATA_WIDTH-1:0]      fwd1_data,
  output logic [DATA_WIDTH-1:0]      fwd2_data
);

  localparam int unsigned PtrW = (NREQ > 2) ? 2 : 1;

  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [PtrW-1:0]       gidx;
  logic                  found;
  logic [NREQ-1:0]       grant;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_waddr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Position k in the search order starting at p, wrapped modulo NREQ.
  function automatic logic [PtrW-1:0] rr_idx(input logic [PtrW-1:0] p, input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return PtrW'(s);
  endfunction

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    grant = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && req_valid[rr_idx(ptr_q, k)]) begin
        found = 1'b1;
        gidx  = rr_idx(ptr_q, k);
      end
    end
    if (found) grant[gidx] = 1'b1;
  end

  // Ready is masked during reset so nothing appears accepted while the stage is held clear.
  assign req_ready = grant & {NREQ{~stall & rst_n}};
  assign accept    = |req_ready;
  assign sel_waddr = req_waddr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = req_wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
  assign ptr_d     = (gidx == PtrW'(NREQ - 1)) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= accept && (sel_waddr != '0);
      if (accept) begin
        ptr_q    <= ptr_d;
        rf_waddr <= sel_waddr;
        rf_wdata <= sel_wdata;
      end
    end
  end

`ifdef RF_ARB_FWD_EN
  assign fwd1_hit  = rf_wen && (rf_waddr == raddr1) && (raddr1 != '0);
  assign fwd2_hit  = rf_wen && (rf_waddr == raddr2) && (raddr2 != '0);
  assign fwd1_data = fwd1_hit ? rf_wdata : '0;
  assign fwd2_data = fwd2_hit ? rf_wdata : '0;
`else
  logic unused_raddr;
  assign unused_raddr = ^{raddr1, raddr2};
  assign fwd1_hit     = 1'b0;
  assign fwd2_hit     = 1'b0;
  assign fwd1_data    = '0;
  assign fwd2_data    = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scoreboard bench for rf_wb_arbiter; forwarding expectations follow RF_ARB_FWD_EN.
module tb_rf_wb_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
`ifdef RF_ARB_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_waddr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic                 stall;
  logic                 rf_wen;
  logic [AW-1:0]        rf_waddr;
  logic [DW-1:0]        rf_wdata;
  logic [AW-1:0]        raddr1, raddr2;
  logic                 fwd1_hit, fwd2_hit;
  logic [DW-1:0]        fwd1_data, fwd2_data;

  logic [AW-1:0] waddr_a [NREQ];
  logic [DW-1:0] wdata_a [NREQ];

  int  checks   = 0;
  int  failures = 0;
  int  m_ptr    = 0;
  wr_t m_out    = '0;
  bit  auto_drop = 1'b0;
  wr_t sb[$];

  always #5 clk = ~clk;

  always_comb begin
    req_waddr = '0;
    req_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_waddr[i*AW +: AW] = waddr_a[i];
      req_wdata[i*DW +: DW] = wdata_a[i];
    end
  end

  rf_wb_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_waddr (req_waddr),
    .req_wdata (req_wdata),
    .stall     (stall),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .fwd1_data (fwd1_data),
    .fwd2_data (fwd2_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic check_fwd(input wr_t e);
    logic          h1, h2;
    h1 = FwdEn && e.wen && (e.addr == raddr1) && (raddr1 != '0);
    h2 = FwdEn && e.wen && (e.addr == raddr2) && (raddr2 != '0);
    chk("fwd1_hit", 64'(fwd1_hit), 64'(h1));
    chk("fwd2_hit", 64'(fwd2_hit), 64'(h2));
    chk("fwd1_data", 64'(fwd1_data), h1 ? 64'(e.data) : 64'd0);
    chk("fwd2_data", 64'(fwd2_data), h2 ? 64'(e.data) : 64'd0);
  endtask

  // Inputs are driven 1 time unit after a rising edge; ready is sampled 1 unit later.
  task automatic cycle();
    int              g;
    logic [NREQ-1:0] exp_rdy;
    wr_t             e;
    #1;
    g       = stall ? -1 : model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (g >= 0) begin
      m_out.wen  = (waddr_a[g] != '0);
      m_out.addr = waddr_a[g];
      m_out.data = wdata_a[g];
      m_ptr      = (g + 1) % NREQ;
    end else begin
      m_out.wen = 1'b0;
    end
    sb.push_back(m_out);
    @(posedge clk);
    #1;
    if (g >= 0 && auto_drop) req_valid[g] = 1'b0;
    e = sb.pop_front();
    chk("rf_wen", 64'(rf_wen), 64'(e.wen));
    chk("rf_waddr", 64'(rf_waddr), 64'(e.addr));
    chk("rf_wdata", 64'(rf_wdata), 64'(e.data));
    check_fwd(e);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    stall     = 1'b0;
    raddr1    = '0;
    raddr2    = '0;
    waddr_a[0] = 5'd1; wdata_a[0] = 32'hA;
    waddr_a[1] = 5'd2; wdata_a[1] = 32'hB;
    waddr_a[2] = 5'd3; wdata_a[2] = 32'hC;

    // Reset with every requester asking.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rf_wen", 64'(rf_wen), 64'd0);
    chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
    check_fwd('0);
    rst_n = 1'b1;

    // Round robin from requester 0, wrapping twice; forwarding watches addresses 2 and 3.
    raddr1 = 5'd2;
    raddr2 = 5'd3;
    repeat (6) cycle();

    // Zero address is consumed without a write; pointer moves to 2.
    auto_drop  = 1'b1;
    req_valid  = 3'b010;
    waddr_a[1] = 5'd0;
    wdata_a[1] = 32'hDEAD;
    raddr1     = 5'd0;
    cycle();
    req_valid  = 3'b111;
    waddr_a[1] = 5'd2;
    cycle();                  // must go to requester 2
    req_valid  = '0;

    // Stall blocks acceptance, then 0 before 2.
    req_valid = 3'b101;
    stall     = 1'b1;
    repeat (3) cycle();
    stall = 1'b0;
    cycle();
    cycle();
    cycle();

    // Forwarding of a presented write for exactly one cycle.
    raddr2     = 5'd5;
    waddr_a[0] = 5'd5;
    wdata_a[0] = 32'h1234;
    req_valid  = 3'b001;
    cycle();
    cycle();

    // Stall rising while a write is presented leaves that write intact.
    waddr_a[1] = 5'd9;
    wdata_a[1] = 32'h99;
    req_valid  = 3'b010;
    cycle();
    stall = 1'b1;
    req_valid = 3'b001;
    cycle();
    stall = 1'b0;
    cycle();

    // Reset mid-flight discards the presented write.
    waddr_a[2] = 5'd7;
    wdata_a[2] = 32'h55;
    req_valid  = 3'b100;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rf_wen", 64'(rf_wen), 64'd0);
    chk("midrst_rf_waddr", 64'(rf_waddr), 64'd0);
    chk("midrst_rf_wdata", 64'(rf_wdata), 64'd0);
    rst_n = 1'b1;
    m_ptr = 0;
    m_out = '0;
    @(posedge clk);
    #1;
    chk("midrst_no_commit", 64'(rf_wen), 64'd0);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Shares the single write port of the 32x32 register file among several writeback requesters (ALU, load unit, multi-cycle unit). Each cycle it grants at most one requester by round-robin priority. It registers the winning write into a one-entry output stage that drives `wen`/`waddr`/`wdata` of the register file. Optional forwarding outputs cover the cycle in which a write is presented but not yet committed.

## Interface

Parameters:
- `NREQ`, 3: number of requesters; legal range 2..4.
- `DATA_WIDTH`, 32: write data width.
- `ADDR_WIDTH`, 5: register address width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset.
- `req_valid`  in  NREQ  per-requester write request.
- `req_ready`  out  NREQ  per-requester accept; combinational.
- `req_waddr`  in  NREQ*ADDR_WIDTH  requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata`  in  NREQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `stall`  in  1  pipeline hold; while 1, no request is accepted.
- `rf_wen`  out  1  register-file write enable; registered.
- `rf_waddr`  out  ADDR_WIDTH  register-file write address; registered.
- `rf_wdata`  out  DATA_WIDTH  register-file write data; registered.
- `raddr1`, `raddr2`  in  ADDR_WIDTH  register-file read addresses, used for forwarding compare.
- `fwd1_hit`, `fwd2_hit`  out  1  the pending write targets `raddr1` / `raddr2`.
- `fwd1_data`, `fwd2_data`  out  DATA_WIDTH  forwarded value.

## Operation

- Round-robin pointer `ptr` (0..NREQ-1) marks the highest-priority requester. The search order is ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
- The grant goes to the first requester in search order with `req_valid`=1.
- `req_ready[i]` = grant[i] & ~stall. At most one bit of `req_ready` is set.
- Acceptance happens when `req_valid[i]` & `req_ready[i]` at a rising edge. On acceptance:
  - the output stage loads `rf_waddr` <= waddr_i and `rf_wdata` <= wdata_i;
  - `rf_wen` <= (waddr_i != 0);
  - `ptr` <= (i+1) mod NREQ.
- When there is no acceptance (no valid, or `stall`=1): `rf_wen` <= 0, `rf_waddr` and `rf_wdata` hold, `ptr` holds.
- A request to address 0 is accepted and consumed but never written and never forwarded.
- Requester rules:
  - hold `req_valid`, `req_waddr` and `req_wdata` stable until accepted;
  - `req_valid` must not depend on `req_ready`.
- The output stage never back-pressures, because the register file accepts a write every cycle. Sustained throughput is one write per cycle.
- Forwarding: `fwdK_hit` = `rf_wen` & (`rf_waddr`==`raddrK`) & (`raddrK`!=0); `fwdK_data` = `rf_wdata` when hit, else 0. Both are combinational.

## Timing

- Reset (`rst_n`=0, asynchronous):
  - `rf_wen`=0, `rf_waddr`=0, `rf_wdata`=0, `ptr`=0;
  - `req_ready` is 0 while `rst_n`=0;
  - `fwd*_hit`=0, `fwd*_data`=0.
- Latency: a request accepted at edge N drives `rf_wen`=1 during cycle N..N+1, and the register file commits at edge N+1. Read-after-write without forwarding is visible from cycle N+1 onward.
- Back-to-back accepts on consecutive edges produce one write per cycle with no bubble.
- Reset asserted mid-operation discards the output-stage write; it is never committed.
- Stall rising while a write is presented does not cancel that write; only new acceptance is blocked.
- Simultaneous valid from all requesters: each is served within NREQ accepted cycles (starvation-free).
- Pointer wrap: a grant to requester NREQ-1 sets `ptr`=0.

## Configuration

- `RF_ARB_FWD_EN` defined: the forwarding compare and the `fwd1_*`/`fwd2_*` outputs are as described above.
- `RF_ARB_FWD_EN` undefined: the compare logic is removed, `fwd1_hit`/`fwd2_hit` are tied to 0, `fwd1_data`/`fwd2_data` are tied to 0, and `raddr1`/`raddr2` are ignored. Arbitration and the output stage are unchanged.

## Test plan

- Reset: drive `rst_n`=0 with all `req_valid`=1 -> `req_ready`=0, `rf_wen`=0, `rf_waddr`=0, `rf_wdata`=0. Release `rst_n` -> requester 0 is granted first.
- Round robin, NREQ=3: all valid continuously, waddr 1/2/3, wdata 0xA/0xB/0xC -> `rf_waddr` sequence is 1,2,3,1,2,3 on consecutive cycles with `rf_wen` held at 1.
- Zero address: requester 1 alone sends waddr=0, wdata=0xDEAD -> `req_ready[1]`=1 for one cycle, then `rf_wen`=0, `fwd1_hit`=0 with `raddr1`=0, and `ptr` advances to 2.
- Stall: requesters 0 and 2 valid with `stall`=1 for 3 cycles -> `req_ready`=0 and `rf_wen`=0 throughout. On `stall`=0, requester 0 is granted first, then requester 2.
- Forwarding (`RF_ARB_FWD_EN` defined): accept waddr=5, wdata=0x1234, and set `raddr2`=5 in the following cycle -> `fwd2_hit`=1 and `fwd2_data`=0x1234 for exactly one cycle. With the macro undefined -> `fwd2_hit`=0.
- Reset mid-flight: accept waddr=7, wdata=0x55, then pulse `rst_n` low before the next edge -> `rf_wen` drops to 0 immediately and register 7 is never written.
